// File: rtl/pellet_map_writer.sv
// Pellet map write-side controller: copies the layout ROM into the pellet RAM and
// clears pellets on eat requests. Optional score accumulator under PELLET_SCORE_EN.
module pellet_map_writer #(
   parameter int COLS = 28,
   parameter int ROWS = 31,
   parameter int AW   = 10
) (
   input  logic          clk_25MHz,
   input  logic          reset,
   input  logic          init_start,
   input  logic          eat_req,
   input  logic [4:0]    tile_row,
   input  logic [4:0]    tile_col,
   output logic          eat_ack,
   output logic [1:0]    eat_kind,
   output logic          busy,
   output logic [9:0]    pellets_left,
   output logic          level_clear,
   output logic [AW-1:0] rom_addr,
   input  logic [1:0]    rom_data,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [1:0]    mem_wdata,
   input  logic [1:0]    mem_rdata,
   output logic [15:0]   score
);

   typedef enum logic [2:0] {IDLE, INIT_COPY, INIT_LAST, EAT_RD, EAT_CHK} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] k, k_nxt;
   logic [4:0]    row_q, col_q;
   logic [9:0]    pellets_q, pellets_nxt, final_cnt;
   logic          clear_q, clear_nxt;
   logic [1:0]    kind_q, kind_nxt;
   logic [1:0]    code;
   logic          latch;
   logic          oor;
   logic [AW-1:0] eat_addr;

   // Layout code 3 is not a pellet and is stored as empty.
   assign code      = (rom_data == 2'd3) ? 2'd0 : rom_data;
   assign eat_addr  = AW'(32'(row_q) * 32'(COLS) + 32'(col_q));
   assign oor       = (32'(row_q) >= ROWS) || (32'(col_q) >= COLS);
   assign final_cnt = pellets_q + {9'd0, code != 2'd0};

   always_ff @(posedge clk_25MHz or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         k         <= '0;
         row_q     <= '0;
         col_q     <= '0;
         pellets_q <= '0;
         clear_q   <= 1'b0;
         kind_q    <= '0;
      end else begin
         state     <= state_nxt;
         k         <= k_nxt;
         pellets_q <= pellets_nxt;
         clear_q   <= clear_nxt;
         kind_q    <= kind_nxt;
         if (latch) begin
            row_q <= tile_row;
            col_q <= tile_col;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      k_nxt       = k;
      pellets_nxt = pellets_q;
      clear_nxt   = clear_q;
      kind_nxt    = kind_q;
      latch       = 1'b0;
      rom_addr    = '0;
      mem_addr    = '0;
      mem_we      = 1'b0;
      mem_wdata   = 2'd0;
      eat_ack     = 1'b0;
      case (state)
         IDLE: begin
            if (init_start) begin
               state_nxt   = INIT_COPY;
               k_nxt       = '0;
               pellets_nxt = '0;
               clear_nxt   = 1'b0;
            end else if (eat_req) begin
               latch     = 1'b1;
               state_nxt = EAT_RD;
            end
         end
         INIT_COPY: begin
            // ROM data lags its address by one cycle, so entry k-1 is written now.
            rom_addr = k;
            k_nxt    = k + AW'(1);
            if (k != '0) begin
               mem_we    = 1'b1;
               mem_addr  = k - AW'(1);
               mem_wdata = code;
               if (code != 2'd0) pellets_nxt = pellets_q + 10'd1;
            end
            if (k == AW'(ROWS * COLS - 1)) state_nxt = INIT_LAST;
         end
         INIT_LAST: begin
            mem_we      = 1'b1;
            mem_addr    = k - AW'(1);
            mem_wdata   = code;
            pellets_nxt = final_cnt;
            clear_nxt   = (final_cnt == 10'd0);
            state_nxt   = IDLE;
         end
         EAT_RD: begin
            if (!oor) mem_addr = eat_addr;
            state_nxt = EAT_CHK;
         end
         EAT_CHK: begin
            eat_ack   = 1'b1;
            kind_nxt  = 2'd0;
            state_nxt = IDLE;
            if (!oor) begin
               mem_addr = eat_addr;
               if (mem_rdata != 2'd0) begin
                  mem_we   = 1'b1;
                  kind_nxt = mem_rdata;
                  if (pellets_q != 10'd0) begin
                     pellets_nxt = pellets_q - 10'd1;
                     if (pellets_q == 10'd1) clear_nxt = 1'b1;
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy         = (state != IDLE);
   assign eat_kind     = (state == EAT_CHK) ? kind_nxt : kind_q;
   assign pellets_left = pellets_q;
   assign level_clear  = clear_q;

`ifdef PELLET_SCORE_EN
   logic [15:0] score_q;
   logic [15:0] credit;
   logic [16:0] score_sum;

   always_comb begin
      credit = '0;
      if (state == EAT_CHK) begin
         case (kind_nxt)
            2'd1:    credit = 16'd10;
            2'd2:    credit = 16'd50;
            default: credit = '0;
         endcase
      end
   end

   assign score_sum = {1'b0, score_q} + {1'b0, credit};

   always_ff @(posedge clk_25MHz or posedge reset) begin
      if (reset)                         score_q <= '0;
      else if (state == IDLE && init_start) score_q <= '0;
      else if (state == EAT_CHK)         score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
   end

   assign score = score_q;
`else
   assign score = '0;
`endif

endmodule

// File: doc/pellet_map_writer.md
# pellet_map_writer

Write-side controller for the pellet map: the dual-port tile RAM that the renderer and movement logic read by tile row/column. On a level start it copies the pellet layout from the layout ROM into the pellet RAM and counts pellets. During play it accepts "Pac-Man entered tile" requests, performs a read-modify-write that clears any pellet on that tile, reports what was eaten, and raises `level_clear` when the last pellet is gone.

## Interface
Parameters:
- `COLS`, default 28: maze width in tiles; address = row*COLS + col.
- `ROWS`, default 31: maze height in tiles; map size = ROWS*COLS = 868 entries.
- `AW`, default 10: RAM/ROM address width.

Ports:
- `clk_25MHz`, in, 1: sole clock; all logic on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `init_start`, in, 1: single-cycle pulse that starts a layout copy.
- `eat_req`, in, 1: eat request; held high until `eat_ack`.
- `tile_row`, in, 5: request row; sampled at acceptance.
- `tile_col`, in, 5: request column; sampled at acceptance.
- `eat_ack`, out, 1: one-cycle completion pulse.
- `eat_kind`, out, 2: code found at the tile (0 none, 1 dot, 2 power); valid with `eat_ack`, held until the next ack.
- `busy`, out, 1: high in every state except IDLE.
- `pellets_left`, out, 10: remaining pellet count.
- `level_clear`, out, 1: level complete flag.
- `rom_addr`, out, AW: layout ROM address; ROM has 1-cycle read latency.
- `rom_data`, in, 2: layout ROM data.
- `mem_addr`, out, AW: pellet RAM port B address; RAM has 1-cycle read latency.
- `mem_we`, out, 1: pellet RAM write enable.
- `mem_wdata`, out, 2: pellet RAM write data.
- `mem_rdata`, in, 2: pellet RAM read data.
- `score`, out, 16: score accumulator. See Configuration.

## Operation
- States:
  - IDLE, INIT_COPY, INIT_LAST, EAT_RD, EAT_CHK.
  - All outputs reset to 0 and the state resets to IDLE.
- IDLE:
  - `init_start` goes to INIT_COPY. It clears `pellets_left`, `level_clear`, `score` and the copy counter.
  - Otherwise, `eat_req` is accepted. The block latches row and col and goes to EAT_RD.
  - If both are high in the same cycle, init wins. The eat request stays pending and is accepted after the copy.
- INIT_COPY:
  - Counter k drives `rom_addr`.
  - Each cycle, the block writes the ROM data for k-1 to `mem_addr`=k-1 with `mem_we`=1, for k≥1.
  - It adds 1 to `pellets_left` for each nonzero code. Code 3 is treated as 0 and written as 0.
  - When k = ROWS*COLS-1, the next state is INIT_LAST.
- INIT_LAST:
  - Writes the final entry.
  - Sets `level_clear` if the final count is 0.
  - Returns to IDLE.
- EAT_RD:
  - Drives `mem_addr` = row*COLS+col.
  - Out-of-range row (≥ROWS) or col (≥COLS) skips the read. The request is then acked in EAT_CHK with `eat_kind`=0 and no write.
- EAT_CHK:
  - `mem_rdata` is valid here.
  - If the code is nonzero: `mem_we`=1 and `mem_wdata`=0 to the same address, `pellets_left` is decremented, and `eat_kind` is set to the code.
  - `eat_ack` pulses. The state returns to IDLE.
  - A decrement to 0 sets `level_clear`. It stays set until the next `init_start` or `reset`.
- Arithmetic:
  - The address is an unsigned product truncated to AW bits.
  - `pellets_left` never decrements below 0.
- `init_start` while `busy` is ignored.
- `eat_req` still high in the cycle after `eat_ack` is a new request.
- Reset mid-operation aborts at once. RAM contents are then undefined until the next init.

## Timing
- Init: `busy` rises the cycle after `init_start` and lasts ROWS*COLS+1 cycles, i.e. 869 with defaults.
  - The first `mem_we` occurs in the 2nd busy cycle.
  - The last `mem_we` occurs in the final busy cycle (INIT_LAST).
- Eat: accepted at edge 0.
  - EAT_RD is cycle 1.
  - `eat_ack` and the write occur in cycle 2.
  - The next acceptance is possible at the edge ending cycle 3.
- Counts and flags update on the edge that ends the write cycle.

## Configuration
- `PELLET_SCORE_EN` defined: `score` adds 10 per dot and 50 per power pellet, on the edge ending EAT_CHK. It saturates at 16'hFFFF and clears on `init_start`.
- `PELLET_SCORE_EN` undefined: the port is present but tied to 0, and no adder is built.

## Test plan
- Init with a ROM of 240 dots and 4 power pellets:
  - `busy` is high for 869 cycles.
  - There are 868 writes at addresses 0..867.
  - `pellets_left`=244 and `level_clear`=0.
- Eat at row 1, col 1 holding a dot:
  - `eat_ack` comes 2 cycles after acceptance.
  - `eat_kind`=1 and a write of 0 to address 29.
  - `pellets_left` goes 244→243.
  - `score`=10 with `PELLET_SCORE_EN` defined.
- Repeat the eat on the same tile: `eat_kind`=0, no `mem_we`, count unchanged.
- Eat at row 31, col 5 (out of range): ack with `eat_kind`=0, no RAM access.
- Init with a single power pellet, then eat it: `pellets_left`=0, `level_clear`=1; a later `init_start` clears the flag.
- `reset` asserted mid-init at k=400: outputs are 0 the same cycle, the state is IDLE, and `init_start` together with `eat_req` starts the init first.
